// File: rtl/sw_pkg.sv
// Shared constants and state encoding for the slide-switch debouncer.
package sw_pkg;

    localparam int unsigned N_SW_DEF            = 10;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
    localparam int unsigned CNT_W_DEF           = 20;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } db_state_e;

endpackage

// File: rtl/sw_debounce_if.sv
// Switch conditioning bus: raw pins in, debounced levels and change pulses out.
interface sw_debounce_if
    import sw_pkg::*;
#(
    parameter int unsigned N_SW = N_SW_DEF
);

    logic [N_SW-1:0] sw_raw;
    logic [N_SW-1:0] sw_out;
    logic [N_SW-1:0] sw_changed;
    logic            any_change;

    modport master (
        output sw_raw,
        input  sw_out,
        input  sw_changed,
        input  any_change
    );

    modport slave (
        input  sw_raw,
        output sw_out,
        output sw_changed,
        output any_change
    );

endinterface

// File: rtl/sw_debounce_bit.sv
// One switch channel: two-flop synchronizer, stability counter and accept FSM.
module sw_debounce_bit
    import sw_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic changed
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             changed_q, changed_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= ST_STABLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            changed_q <= changed_d;
        end
    end

    // Counter only runs while sync2 disagrees with the accepted level; any return resets it.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        changed_d = 1'b0;
        unique case (state_q)
            ST_STABLE: begin
                if (sync2_q != level_q) begin
                    state_d = ST_COUNTING;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_COUNTING: begin
                if (sync2_q == level_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_STABLE;
                    cnt_d     = '0;
                    level_d   = sync2_q;
                    changed_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign level   = level_q;
    assign changed = changed_q;

endmodule

// File: rtl/sw_debounce.sv
// Debounces N_SW asynchronous slide switches into a clean registered vector plus change pulses.
module sw_debounce
    import sw_pkg::*;
#(
    parameter int unsigned N_SW            = N_SW_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    sw_debounce_if.slave sw
);

    logic [N_SW-1:0] level_w;
    logic [N_SW-1:0] changed_w;

    for (genvar i = 0; i < N_SW; i++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .raw     (sw.sw_raw[i]),
            .level   (level_w[i]),
            .changed (changed_w[i])
        );
    end

    assign sw.sw_out     = level_w;
    assign sw.sw_changed = changed_w;
    assign sw.any_change = |changed_w;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with DEBOUNCE_CYCLES=4; per-edge expectations held in a scoreboard queue.
module tb_sw_debounce;

    localparam int unsigned N   = 10;
    localparam int unsigned DB  = 4;
    localparam int unsigned LAT = DB + 2;   // edges from a clean raw change to acceptance

    typedef struct {
        string        tag;
        logic [N-1:0] out;
        logic [N-1:0] chg;
    } exp_t;

    logic   clk = 1'b0;
    logic   reset_n;
    int     checks = 0;
    int     errors = 0;
    exp_t   sb[$];

    sw_debounce_if #(.N_SW(N)) bus ();

    sw_debounce #(
        .N_SW            (N),
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (20)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sw      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic push_idle(input string tag, input int n, input logic [N-1:0] out);
        for (int k = 0; k < n; k++) sb.push_back('{tag, out, '0});
    endtask

    // Old level until the acceptance edge, one pulse there, then quiet.
    task automatic push_accept(input string tag, input logic [N-1:0] old_v,
                               input logic [N-1:0] new_v, input logic [N-1:0] chg);
        push_idle(tag, int'(LAT) - 1, old_v);
        sb.push_back('{tag, new_v, chg});
        push_idle(tag, 2, new_v);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            @(posedge clk);
            #1;
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL scoreboard: observed empty queue expected an entry");
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check({e.tag, "/sw_out"},     bus.sw_out,     e.out);
                check({e.tag, "/sw_changed"}, bus.sw_changed, e.chg);
                check({e.tag, "/any_change"}, N'(bus.any_change), N'(|e.chg));
            end
        end
    endtask

    task automatic drain();
        run(sb.size());
    endtask

    initial begin
        // 1: reset with all switches high, then power-up acceptance
        reset_n    = 1'b0;
        bus.sw_raw = 10'h3FF;
        #2;
        check("s1_rst/sw_out",     bus.sw_out,     '0);
        check("s1_rst/sw_changed", bus.sw_changed, '0);
        push_idle("s1_rst", 3, '0);
        drain();
        @(negedge clk);
        reset_n = 1'b1;
        push_accept("s1_init", '0, 10'h3FF, 10'h3FF);
        drain();

        bus.sw_raw = '0;
        push_accept("s1_clear", 10'h3FF, '0, 10'h3FF);
        drain();

        // 2: clean rise and fall on bit 0
        bus.sw_raw = 10'h001;
        push_accept("s2_rise", '0, 10'h001, 10'h001);
        drain();
        bus.sw_raw = '0;
        push_accept("s2_fall", 10'h001, '0, 10'h001);
        drain();

        // 3: bounce on bit 3 never lasts long enough
        bus.sw_raw = 10'h008; push_idle("s3_bounce", 2, '0); run(2);
        bus.sw_raw = 10'h000; push_idle("s3_bounce", 1, '0); run(1);
        bus.sw_raw = 10'h008; push_idle("s3_bounce", 2, '0); run(2);
        bus.sw_raw = 10'h000; push_idle("s3_bounce", 10, '0);
        drain();

        // 4: short bounce on bit 5 then held high
        bus.sw_raw = 10'h020; push_idle("s4_bounce", 1, '0); run(1);
        bus.sw_raw = 10'h000; push_idle("s4_bounce", 1, '0); run(1);
        bus.sw_raw = 10'h020;
        push_accept("s4_settle", '0, 10'h020, 10'h020);
        drain();
        bus.sw_raw = '0;
        push_accept("s4_fall", 10'h020, '0, 10'h020);
        drain();

        // 5: bits 1 and 9 together, bit 4 one cycle later
        bus.sw_raw = 10'h202; push_idle("s5_stagger", 1, '0); run(1);
        bus.sw_raw = 10'h212;
        push_idle("s5_stagger", int'(LAT) - 2, '0);
        sb.push_back('{"s5_pair", 10'h202, 10'h202});
        sb.push_back('{"s5_late", 10'h212, 10'h010});
        push_idle("s5_after", 2, 10'h212);
        drain();

        // 6: async reset while bit 2 counter is at 2
        bus.sw_raw = 10'h216;
        push_idle("s6_count", 4, 10'h212);
        drain();
        #2;
        reset_n = 1'b0;
        #1;
        check("s6_async/sw_out",     bus.sw_out,     '0);
        check("s6_async/sw_changed", bus.sw_changed, '0);
        check("s6_async/any_change", N'(bus.any_change), '0);
        push_idle("s6_hold", 2, '0);
        drain();
        @(negedge clk);
        reset_n = 1'b1;
        push_accept("s6_restart", '0, 10'h216, 10'h216);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Conditions the raw slide-switch inputs before they reach the switch read slave. Each of the N_SW asynchronous switch lines passes through a two-flop synchronizer and a per-bit debounce counter. The block emits a clean, registered switch vector that feeds the read slave's SW_in port directly. It also emits one-cycle change pulses for future edge-capture or interrupt logic.

## Interface
- N_SW, 10, number of switch channels.
- DEBOUNCE_CYCLES, 500000, consecutive synchronized-stable cycles required to accept a new level (10 ms at 50 MHz); legal range 2 to 2^CNT_W-1.
- CNT_W, 20, debounce counter width.

- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- sw_raw  in  N_SW  raw switch pins, asynchronous to clk, may bounce.
- sw_out  out  N_SW  debounced switch levels, registered; connects to SW_in of the switch read slave.
- sw_changed  out  N_SW  one-cycle pulse per bit on the clock edge where that bit of sw_out toggles.
- any_change  out  1  OR of sw_changed, combinational from registered sw_changed.

## Operation
- Reset (asynchronous assert, synchronous-to-clk release): both synchronizer stages, all counters, sw_out and sw_changed go to 0; any_change therefore reads 0.
- Per bit, the two stages are sync1 <= sw_raw and sync2 <= sync1. All decisions use sync2 only.
- Each bit runs a two-state machine:
  - STABLE: the counter is 0. If sync2 != sw_out, go to COUNTING and set the counter to 1.
  - COUNTING, with sync2 == sw_out (bounce returned): go to STABLE and set the counter to 0. sw_out is unchanged and no pulse is generated.
  - COUNTING, with sync2 != sw_out and counter < DEBOUNCE_CYCLES-1: increment the counter.
  - COUNTING, with sync2 != sw_out and counter == DEBOUNCE_CYCLES-1: sw_out <= sync2, sw_changed bit <= 1, counter <= 0, go to STABLE.
- sw_changed is 0 in every cycle except the acceptance cycle. It never stays high for two consecutive cycles on the same bit.
- Channels are fully independent. Simultaneous changes on several bits each complete on their own schedule; equal timing gives pulses on the same edge.
- The counter saturates by construction and never wraps, because it resets on acceptance or on return to the old level.
- After reset release with a switch held at 1, that bit is accepted as a normal change. sw_out goes to 1 with a sw_changed pulse after the standard latency.

## Timing
- Latency: a clean level change on sw_raw meeting setup before edge E0 appears on sw_out and sw_changed after edge E0+DEBOUNCE_CYCLES+1.
  - E0: sync1 captures the new level.
  - E1: sync2 captures it.
  - E2 to E(DEBOUNCE_CYCLES+1): the counter runs; acceptance happens on the last of these edges.
- Minimum accepted pulse: a level is accepted only if sync2 holds the new value for DEBOUNCE_CYCLES consecutive compare edges. A raw glitch shorter than DEBOUNCE_CYCLES-1 clock periods is always rejected.
- sw_changed and sw_out update on the same edge. any_change follows sw_changed within the same cycle.
- Downstream, the read slave adds its own one-cycle register. Switch-to-readdata latency is therefore DEBOUNCE_CYCLES+3 edges.

## Structure
- A shared package sw_pkg holds:
  - the channel count constant;
  - the default debounce count;
  - the two-state enum (ST_STABLE, ST_COUNTING) used by the per-bit machine.
- Sub-module sw_debounce_bit contains one synchronizer, one counter and one state machine, with ports clk, reset_n, raw, level, changed. The top module instantiates it N_SW times in a generate loop and ORs the changed outputs into any_change.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and N_SW=10.
1. Reset with sw_raw=10'h3FF held: sw_out=0, sw_changed=0 during reset. After release, sw_out=10'h3FF and sw_changed=10'h3FF exactly on edge 6 after release, then sw_changed=0.
2. Clean 0->1 on bit 0 before E0: sw_out[0] rises at E0+5, single-cycle sw_changed[0]=1, any_change=1 in that cycle only. 1->0 then behaves symmetrically.
3. Bounce on bit 3 (high 2 cycles, low 1, high 2, low thereafter): sw_out[3] stays 0 and sw_changed stays 0 throughout.
4. Bounce on bit 5 (high 1, low 1, then high held): sw_out[5] rises 4 compare edges after sync2 settles high, with exactly one sw_changed pulse.
5. Bits 1 and 9 change on the same edge, bit 4 one cycle later: sw_changed=10'h202 on one edge and 10'h010 on the next. sw_out ends at 10'h212.
6. reset_n asserted mid-count on bit 2 (counter=2): all outputs 0 immediately, without waiting for a clock edge. After release the full 6-edge latency restarts from zero.
